// File: rtl/bus_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_alu_pkg
//  Description : Shared types for the bus ALU sequencer. It defines the ALU
//                operation codes and the micro-sequencer state encoding.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package bus_alu_pkg;

    localparam int OP_W = 3;

    // ALU operation codes. Code 3'b111 is unnamed and executes as PASSA.
    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_PASSA = 3'b101,
        OP_PASSB = 3'b110
    } alu_op_t;

    // Micro-sequencer phases: IDLE (T0 accept), EXEC (T1), WB (T2).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } seq_state_t;

endpackage : bus_alu_pkg
`default_nettype wire

// File: rtl/bus_alu.sv
`default_nettype none
// ============================================================================
//  Module      : bus_alu
//  Description : A purely combinational multi-op ALU. It takes two operands
//                and an op code and returns the result and the carry/borrow.
//                Optional macro BUS_ALU_SATURATE_EN: when it is defined, ADD
//                clamps to all-ones on overflow and SUB clamps to zero on
//                underflow. The carry output always reports the raw
//                carry/borrow.
//  Ports       : a, b   - operands (DR1, DR2)
//                op     - operation code
//                result - WIDTH-bit result
//                carry  - carry-out (ADD) or borrow (SUB), 0 otherwise
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module bus_alu
    import bus_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // A single extra bit holds the carry-out for ADD.
    // For SUB, that bit goes high exactly when a < b, so it is the borrow.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                carry = w_sum[WIDTH];
`ifdef BUS_ALU_SATURATE_EN
                result = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
                result = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                carry = w_diff[WIDTH];
`ifdef BUS_ALU_SATURATE_EN
                result = w_diff[WIDTH] ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
`else
                result = w_diff[WIDTH-1:0];
`endif
            end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            default:  result = a;
        endcase
    end

endmodule : bus_alu
`default_nettype wire

// File: rtl/bus_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_alu_sequencer
//  Description : Contains a bank of NREG general registers, the operand
//                registers DR1/DR2 and the accumulator AC, all behind a
//                multi-op ALU. An internal sequencer (IDLE -> EXEC -> WB)
//                runs each command under a valid/ready handshake. The block
//                also has a host register-write port and a bus-driven output
//                register (outr).
//                Optional macro BUS_ALU_SATURATE_EN: the ALU saturates on
//                ADD/SUB (see bus_alu).
//  Ports       : clk, rst (async, active-low)
//                cmd_valid/cmd_ready, cmd_op, cmd_a, cmd_b, cmd_dst - command
//                wr_en, wr_addr, wr_data - host register write
//                out_en, out_sel, outr   - output register load
//                rsp_valid, rsp_data     - one-cycle completion pulse + result
//                flag_c, flag_z          - flags of the last EXEC
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module bus_alu_sequencer
    import bus_alu_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREG  = 4,
    localparam int RW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [RW-1:0]    cmd_a,
    input  logic [RW-1:0]    cmd_b,
    input  logic [RW-1:0]    cmd_dst,
    input  logic             wr_en,
    input  logic [RW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             out_en,
    input  logic [RW-1:0]    out_sel,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             flag_c,
    output logic             flag_z,
    output logic [WIDTH-1:0] outr
);

    logic [WIDTH-1:0] r_regs [NREG];
    seq_state_t       r_state;
    logic [WIDTH-1:0] r_dr1;
    logic [WIDTH-1:0] r_dr2;
    logic [WIDTH-1:0] r_ac;
    logic [OP_W-1:0]  r_op;
    logic [RW-1:0]    r_dst;
    logic             r_flag_c;
    logic             r_flag_z;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [WIDTH-1:0] r_outr;

    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] w_rd_out;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;
    logic             w_wb;

    // Bus reads use a match-loop instead of a direct array index. As a
    // result, an index with no register behind it (NREG not a power of 2)
    // reads as zero without any extra range check.
    always_comb begin
        w_rd_a   = '0;
        w_rd_b   = '0;
        w_rd_out = '0;
        for (int i = 0; i < NREG; i++) begin
            if (cmd_a   == RW'(i)) w_rd_a   = r_regs[i];
            if (cmd_b   == RW'(i)) w_rd_b   = r_regs[i];
            if (out_sel == RW'(i)) w_rd_out = r_regs[i];
        end
    end

    assign w_wb = (r_state == WB);

    // Register bank. A write-back takes priority over a host write to the
    // same register. A write to an index with no register matches nothing
    // and is therefore dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wb && r_dst == RW'(i))
                    r_regs[i] <= r_ac;
                else if (wr_en && wr_addr == RW'(i))
                    r_regs[i] <= wr_data;
            end
        end
    end

    bus_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (r_dr1),
        .b      (r_dr2),
        .op     (r_op),
        .result (w_alu_res),
        .carry  (w_alu_carry)
    );

    // Micro-sequencer. Operands are captured from the pre-edge register
    // contents, so a host write on the accept edge is not seen by them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_dr1       <= '0;
            r_dr2       <= '0;
            r_ac        <= '0;
            r_op        <= '0;
            r_dst       <= '0;
            r_flag_c    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_dr1   <= w_rd_a;
                        r_dr2   <= w_rd_b;
                        r_op    <= cmd_op;
                        r_dst   <= cmd_dst;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_ac     <= w_alu_res;
                    r_flag_c <= w_alu_carry;
                    r_flag_z <= (w_alu_res == '0);
                    r_state  <= WB;
                end
                WB: begin
                    r_rsp_data  <= r_ac;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // outr samples the pre-edge bus value, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_outr <= '0;
        else if (out_en)
            r_outr <= w_rd_out;
    end

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign flag_c    = r_flag_c;
    assign flag_z    = r_flag_z;
    assign outr      = r_outr;

endmodule : bus_alu_sequencer
`default_nettype wire

// File: tb/tb_bus_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bus_alu_sequencer
//  Description : Self-checking bench for bus_alu_sequencer. It uses directed
//                vectors, a cycle-level reference model and a per-cycle
//                compare. Expectations follow BUS_ALU_SATURATE_EN when it is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_alu_sequencer;
    import bus_alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int NREG  = 4;
    localparam int RW    = $clog2(NREG);
    localparam int FULL  = 1 << WIDTH;

`ifdef BUS_ALU_SATURATE_EN
    localparam int EXP_ADD   = 15;
    localparam int EXP_SUB   = 0;
    localparam int EXP_SUB_Z = 1;
`else
    localparam int EXP_ADD   = 1;
    localparam int EXP_SUB   = 13;
    localparam int EXP_SUB_Z = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [RW-1:0]    cmd_a = '0;
    logic [RW-1:0]    cmd_b = '0;
    logic [RW-1:0]    cmd_dst = '0;
    logic             wr_en = 1'b0;
    logic [RW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             out_en = 1'b0;
    logic [RW-1:0]    out_sel = '0;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             flag_c;
    logic             flag_z;
    logic [WIDTH-1:0] outr;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    bus_alu_sequencer #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_dst   (cmd_dst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_en    (out_en),
        .out_sel   (out_sel),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .outr      (outr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model computes the result with plain integer arithmetic when the
    // command is accepted. It then releases the flags one edge later, and the
    // write-back/response two edges later.
    function automatic void m_alu(input int op, input int a, input int b,
                                  output int r, output bit c);
        c = 1'b0;
        case (op)
            0: begin
                r = a + b;
                c = (r >= FULL);
`ifdef BUS_ALU_SATURATE_EN
                if (c) r = FULL - 1;
`endif
                r = r % FULL;
            end
            1: begin
                c = (a < b);
                r = c ? a - b + FULL : a - b;
`ifdef BUS_ALU_SATURATE_EN
                if (c) r = 0;
`endif
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            6: r = b;
            default: r = a;
        endcase
    endfunction

    int               m_regs [NREG];
    int               m_phase;
    int               m_res;
    bit               m_c;
    int               m_dst;
    logic             m_ready;
    logic             m_rsp_valid;
    logic             m_fc;
    logic             m_fz;
    int               m_rsp_data;
    int               m_outr;

    always @(posedge clk or negedge rst) begin : p_model
        int old [NREG];
        int r;
        bit c;
        if (!rst) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = 0;
            m_phase = 0; m_res = 0; m_c = 0; m_dst = 0;
            m_ready = 1'b1; m_rsp_valid = 1'b0; m_fc = 1'b0; m_fz = 1'b0;
            m_rsp_data = 0; m_outr = 0;
        end else begin
            old = m_regs;
            m_rsp_valid = 1'b0;
            if (out_en) m_outr = (int'(out_sel) < NREG) ? old[out_sel] : 0;
            if (wr_en && int'(wr_addr) < NREG) m_regs[wr_addr] = int'(wr_data);
            if (m_phase == 0) begin
                if (cmd_valid) begin
                    m_alu(int'(cmd_op),
                          (int'(cmd_a) < NREG) ? old[cmd_a] : 0,
                          (int'(cmd_b) < NREG) ? old[cmd_b] : 0, r, c);
                    m_res = r; m_c = c; m_dst = int'(cmd_dst);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_fc = m_c;
                m_fz = (m_res == 0);
                m_phase = 2;
            end else begin
                if (m_dst < NREG) m_regs[m_dst] = m_res;
                m_rsp_data  = m_res;
                m_rsp_valid = 1'b1;
                m_phase = 0;
            end
            m_ready = (m_phase == 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmd_ready", int'(cmd_ready), int'(m_ready));
            chk("rsp_valid", int'(rsp_valid), int'(m_rsp_valid));
            chk("rsp_data",  int'(rsp_data),  m_rsp_data);
            chk("flag_c",    int'(flag_c),    int'(m_fc));
            chk("flag_z",    int'(flag_z),    int'(m_fz));
            chk("outr",      int'(outr),      m_outr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hwrite(input logic [RW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic show(input logic [RW-1:0] s);
        out_en = 1'b1; out_sel = s;
        tick();
        out_en = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [RW-1:0] a,
                           input logic [RW-1:0] b, input logic [RW-1:0] d);
        int lat;
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 20) begin tick(); guard++; end
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_dst = d;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin tick(); lat++; end
        chk("latency", lat, 3);
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : p_stim
        int exp_tab [6];
        int prev;
        int nacc;
        int npulse;
        exp_tab = '{2, 15, 13, 7, 10, 7};

        #2 rst = 1'b0;
        cmp_on = 1'b1;
        repeat (3) tick();
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_outr", int'(outr), 0);
        chk("reset_flags", int'({flag_c, flag_z}), 0);
        rst = 1'b1;
        tick();

        // ADD 7 + 10
        hwrite(2'd0, 4'd7);
        hwrite(2'd1, 4'd10);
        run_cmd(3'(OP_ADD), 2'd0, 2'd1, 2'd2);
        chk("add_data", int'(rsp_data), EXP_ADD);
        chk("add_c", int'(flag_c), 1);
        chk("add_z", int'(flag_z), 0);
        show(2'd2);
        chk("add_r2", int'(outr), EXP_ADD);

        // SUB 7 - 10 and SUB 10 - 10
        run_cmd(3'(OP_SUB), 2'd0, 2'd1, 2'd3);
        chk("sub_data", int'(rsp_data), EXP_SUB);
        chk("sub_c", int'(flag_c), 1);
        chk("sub_z", int'(flag_z), EXP_SUB_Z);
        run_cmd(3'(OP_SUB), 2'd1, 2'd1, 2'd3);
        chk("sub0_data", int'(rsp_data), 0);
        chk("sub0_c", int'(flag_c), 0);
        chk("sub0_z", int'(flag_z), 1);

        // Logic/pass ops, including the unnamed code 111 (acts as PASSA)
        for (int i = 0; i < 6; i++) begin
            run_cmd(3'(i + 2), 2'd0, 2'd1, 2'd3);
            chk("logic_data", int'(rsp_data), exp_tab[i]);
            chk("logic_c", int'(flag_c), 0);
        end

        // cmd_valid held for 10 cycles with changing fields
        prev = -1; nacc = 0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cmd_op  = 3'($urandom_range(0, 7));
            cmd_a   = RW'($urandom_range(0, NREG - 1));
            cmd_b   = RW'($urandom_range(0, NREG - 1));
            cmd_dst = RW'($urandom_range(0, NREG - 1));
            if (cmd_ready) begin
                if (prev >= 0) begin
                    chk("accept_gap", k - prev, 3);
                    chk("rsp_in_accept_cycle", int'(rsp_valid), 1);
                end
                prev = k;
                nacc++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        chk("accept_count", nacc, 4);
        repeat (4) tick();

        // Host write vs write-back on the same edge, and outr old-value rule
        hwrite(2'd0, 4'd4);
        hwrite(2'd1, 4'd5);
        hwrite(2'd2, 4'd4);
        cmd_valid = 1'b1; cmd_op = 3'(OP_ADD); cmd_a = 2'd0; cmd_b = 2'd1; cmd_dst = 2'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd5;
        out_en = 1'b1; out_sel = 2'd2;
        tick();
        wr_en = 1'b0; out_en = 1'b0;
        chk("wb_rsp_valid", int'(rsp_valid), 1);
        chk("wb_rsp_data", int'(rsp_data), 9);
        chk("outr_old", int'(outr), 4);
        show(2'd2);
        chk("outr_new", int'(outr), 9);
        out_sel = 2'd0;
        repeat (2) tick();
        chk("outr_hold", int'(outr), 9);

        // Host write on the accept edge: operand sees the old R0
        cmd_valid = 1'b1; cmd_op = 3'(OP_PASSA); cmd_a = 2'd0; cmd_b = 2'd1; cmd_dst = 2'd3;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd12;
        tick();
        cmd_valid = 1'b0; wr_en = 1'b0;
        repeat (2) tick();
        chk("accept_wr_rsp_valid", int'(rsp_valid), 1);
        chk("accept_wr_old_operand", int'(rsp_data), 4);
        show(2'd0);
        chk("accept_wr_r0", int'(outr), 12);

        // Reset during EXEC aborts the command
        cmd_valid = 1'b1; cmd_op = 3'(OP_ADD); cmd_a = 2'd0; cmd_b = 2'd1; cmd_dst = 2'd3;
        tick();
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_outr", int'(outr), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_rsp_data", int'(rsp_data), 0);
        repeat (2) tick();
        rst = 1'b1;
        chk("release_ready", int'(cmd_ready), 1);
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid) npulse++;
        end
        chk("abort_no_rsp", npulse, 0);
        show(2'd3);
        chk("abort_r3", int'(outr), 0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_alu_sequencer
`default_nettype wire

// File: doc/bus_alu_sequencer.md
Name: bus_alu_sequencer

Overview:
- Parametrised successor of the 4-bit bus datapath: a bank of NREG general registers, two operand registers DR1/DR2, and an accumulator AC behind a multi-op ALU.
- Replaces the externally driven T0..T3 load strobes with an internal micro-sequencer that runs each command under a valid/ready handshake.
- Keeps the bus-driven output register (outr) and adds a host register-write port.
- Sits between the control unit, which issues commands, and the output/display logic.

Parameters:
- WIDTH, 4: data width of all registers, the ALU and outr.
- NREG, 4: number of general registers (>=2). Register index width RW = $clog2(NREG).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high when the sequencer can accept a command (state IDLE).
- cmd_op  in  3  ALU operation code.
- cmd_a  in  RW  register index routed to bus 1, loaded into DR1.
- cmd_b  in  RW  register index routed to bus 2, loaded into DR2.
- cmd_dst  in  RW  destination register index.
- wr_en  in  1  host register write.
- wr_addr  in  RW  host write index.
- wr_data  in  WIDTH  host write data.
- out_en  in  1  load outr from the register selected by out_sel (successor of the E input).
- out_sel  in  RW  register index driven onto bus 1 for the outr load.
- rsp_valid  out  1  one-cycle pulse: command completed.
- rsp_data  out  WIDTH  result written back.
- flag_c  out  1  carry/borrow of the last EXEC.
- flag_z  out  1  result == 0 from the last EXEC.
- outr  out  WIDTH  output register.

Behaviour:
- Reset (rst=0, asynchronous): all general registers, DR1, DR2, AC, outr, rsp_data, flags = 0; rsp_valid = 0; state = IDLE.
- Sequencer states: IDLE -> EXEC -> WB -> IDLE. cmd_ready = (state == IDLE); there is no combinational path from cmd_valid to cmd_ready.
- Accept edge (IDLE and cmd_valid), T0 phase:
  - DR1 <= R[cmd_a], DR2 <= R[cmd_b].
  - Latch op and dst internally; state -> EXEC.
- EXEC edge (T1 phase): AC <= ALU(DR1, DR2, op); flag_c and flag_z updated; state -> WB.
- WB edge (T2 phase): R[dst] <= AC, rsp_data <= AC, rsp_valid <= 1; state -> IDLE.
  - rsp_valid is high for exactly the single cycle after the WB edge.
- Latency: rsp_valid is high 3 edges after acceptance. A new command may be accepted in the cycle rsp_valid is high, so throughput is 1 command per 3 cycles.
- cmd_valid held while cmd_ready=0: ignored; the command is not accepted until IDLE.
- ALU operation codes:
  - 000 ADD: flag_c = carry-out.
  - 001 SUB (DR1-DR2): flag_c = borrow (DR1<DR2).
  - 010 AND, 011 OR, 100 XOR: flag_c = 0.
  - 101 PASSA, 110 PASSB: flag_c = 0.
  - 111: treated as PASSA.
  - All results are truncated to WIDTH bits unless the optional feature is enabled.
- Host write: R[wr_addr] <= wr_data in any state.
  - Host write and WB to the same register on the same edge: WB wins.
  - Host write on the accept edge: operands read the pre-write value.
- outr: on an out_en edge, outr <= R[out_sel] in any state.
  - Same edge as WB or host write to that register: outr takes the old value.
  - outr holds its value otherwise.
- cmd_a == cmd_b is legal. cmd_dst may equal cmd_a or cmd_b.
- Out-of-range indices (NREG not a power of 2) read 0, and writes to them are dropped.
- Reset mid-operation aborts the command: no rsp_valid, state IDLE, and cmd_ready is high on the first cycle after reset release.

Optional Feature:
- Macro BUS_ALU_SATURATE_EN.
- Defined: ADD clamps to 2^WIDTH-1 on overflow and SUB clamps to 0 on underflow. flag_c still reports the raw carry or borrow.
- Undefined: ADD and SUB wrap modulo 2^WIDTH.

Decomposition:
- Shared package bus_alu_pkg holds:
  - alu_op_t enum: OP_ADD..OP_PASSB.
  - seq_state_t enum: IDLE, EXEC, WB.
- One sub-module, bus_alu (combinational: operands, op -> result, carry), so the saturate macro is isolated there.
- Register bank and sequencer stay in bus_alu_sequencer.

Test Plan:
- Reset: rst=0 mid-run -> all outputs 0, cmd_ready=1 after release. rst=0 during EXEC -> no rsp_valid pulse, R[dst] unchanged.
- WIDTH=4: host write R0=7, R1=10; ADD a=0 b=1 dst=2 -> rsp_valid exactly 3 edges after accept, rsp_data=1, flag_c=1, flag_z=0, R2=1. With BUS_ALU_SATURATE_EN: rsp_data=15.
- SUB a=0 b=1 (7-10) -> rsp_data=13, flag_c=1. With the macro: rsp_data=0, flag_z=1. SUB a=1 b=1 -> 0, flag_z=1, flag_c=0.
- cmd_valid held high for 10 cycles with changing fields -> accepts only when cmd_ready=1. Back-to-back accepts are 3 cycles apart; a new command is accepted in the rsp_valid cycle.
- Host write R2=5 on the WB edge of a command with dst=2 (result 9) -> R2=9. Host write on the accept edge to R0 -> operand uses the old R0.
- out_en with out_sel=2 on the WB edge writing 9 over old 4 -> outr=4. Next out_en -> outr=9, then outr holds while out_en=0.
